lab7_soc_sw_ctrl: RTL and testbench

LAB7_SOC_SW_CTRL -- requirements
Module: lab7_soc_sw_ctrl

---
 rtl/lab7_soc_sw_ctrl.sv | 150 +++++++++++++++
 tb/tb_lab7_soc_sw_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lab7_soc_sw_ctrl.sv
// lab7_soc_sw_ctrl: switch debouncer with an Avalon-MM register window.
// The raw switch inputs pass through a 2-flop synchronizer. Each bit is then
// sampled on a periodic tick into a 3-deep history, and sw_clean only takes a
// new value once three samples in a row agree.
// Define LAB7_SW_CTRL_IRQ_EN to build the interrupt path (intmask, edgecap,
// irq). Without it, addresses 2 and 3 read as zero and irq is tied low.
// Register map: 0 sw_clean (RO), 1 sw_sync (RO), 2 intmask (RW),
// 3 edgecap (RO, write 1 to clear a bit).
`timescale 1ns/1ps
module lab7_soc_sw_ctrl #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic             irq
);

   localparam int            CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sw_meta;
   logic [WIDTH-1:0] sw_sync;
   logic [WIDTH-1:0] h0, h1, h2;
   logic [WIDTH-1:0] agree;
   logic [CW-1:0]    count;
   logic             tick;
   logic             tick_d;
   logic             rd_en;
   logic [WIDTH-1:0] mask_rd;
   logic [WIDTH-1:0] cap_rd;
   logic [31:0]      rd_next;
   logic             unused_wdata;

   // Writedata bits above WIDTH-1 (and all of it without the irq path) are
   // deliberately ignored.
   assign unused_wdata = ^writedata;
   assign rd_en        = chipselect & write_n;
   assign tick         = (count == LAST);
   assign agree        = ~(h0 ^ h1) & ~(h1 ^ h2);

   // Two-stage synchronizer for the asynchronous switch levels.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_raw;
         sw_sync <= sw_meta;
      end
   end

   // Sample-period counter: 0 .. DEBOUNCE_CYCLES-1, then wrap.
   always_ff @(posedge clk) begin
      if (!reset_n)  count <= '0;
      else if (tick) count <= '0;
      else           count <= count + 1'b1;
   end

   // Shift a new synchronized sample into the history on every tick.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h0     <= '0;
         h1     <= '0;
         h2     <= '0;
         tick_d <= 1'b0;
      end else begin
         tick_d <= tick;
         if (tick) begin
            h0 <= sw_sync;
            h1 <= h0;
            h2 <= h1;
         end
      end
   end

   // One cycle after a tick, adopt bits whose three samples agree.
   always_ff @(posedge clk) begin
      if (!reset_n)    sw_clean <= '0;
      else if (tick_d) sw_clean <= (sw_clean & ~agree) | (h0 & agree);
   end

`ifdef LAB7_SW_CTRL_IRQ_EN
   logic             wr_en;
   logic [WIDTH-1:0] wdata_w;
   logic [WIDTH-1:0] sw_clean_d;
   logic [WIDTH-1:0] intmask, intmask_next;
   logic [WIDTH-1:0] edgecap, edgecap_next;

   assign wr_en   = chipselect & ~write_n;
   assign wdata_w = writedata[WIDTH-1:0];
   assign mask_rd = intmask;
   assign cap_rd  = edgecap;

   // Next-state for the mask and capture registers. A new edge is OR-ed in
   // after the clear, so it wins over a simultaneous clear of the same bit.
   always_comb begin
      intmask_next = intmask;
      edgecap_next = edgecap;
      if (wr_en && address == 2'd2) intmask_next = wdata_w;
      if (wr_en && address == 2'd3) edgecap_next = edgecap & ~wdata_w;
      edgecap_next = edgecap_next | (sw_clean ^ sw_clean_d);
   end

   // irq is computed from the next register values, so it tracks
   // edgecap/intmask in the same cycle instead of trailing them.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sw_clean_d <= '0;
         intmask    <= '0;
         edgecap    <= '0;
         irq        <= 1'b0;
      end else begin
         sw_clean_d <= sw_clean;
         intmask    <= intmask_next;
         edgecap    <= edgecap_next;
         irq        <= |(edgecap_next & intmask_next);
      end
   end
`else
   assign mask_rd = '0;
   assign cap_rd  = '0;
   assign irq     = 1'b0;
`endif

   // Read mux, zero-extended to the 32-bit bus.
   always_comb begin
      rd_next = '0;
      case (address)
         2'd0:    rd_next[WIDTH-1:0] = sw_clean;
         2'd1:    rd_next[WIDTH-1:0] = sw_sync;
         2'd2:    rd_next[WIDTH-1:0] = mask_rd;
         default: rd_next[WIDTH-1:0] = cap_rd;
      endcase
   end

   // Registered read data; it holds its value between reads.
   always_ff @(posedge clk) begin
      if (!reset_n)   readdata <= '0;
      else if (rd_en) readdata <= rd_next;
   end

endmodule

// File: tb/tb_lab7_soc_sw_ctrl.sv
// Directed bench for lab7_soc_sw_ctrl with DEBOUNCE_CYCLES=4, WIDTH=16.
// Expected values for the interrupt path depend on LAB7_SW_CTRL_IRQ_EN.
`timescale 1ns/1ps
module tb_lab7_soc_sw_ctrl;
   localparam int WIDTH = 16;
   localparam int DB    = 4;
`ifdef LAB7_SW_CTRL_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_clean;
   logic             irq;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          k;
   logic        found;
   logic [31:0] d;
   logic [15:0] seen;

   lab7_soc_sw_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .sw_raw(sw_raw), .sw_clean(sw_clean), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = v;
      cyc(1);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
      chipselect = 1'b1; write_n = 1'b1; address = a;
      cyc(1);
      v = readdata;
      chipselect = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; address = 2'd1; chipselect = 1'b1; write_n = 1'b1;
      writedata = '0; sw_raw = 16'hFFFF;
      cyc(3);
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_sw_clean", {16'h0, sw_clean}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chipselect = 1'b0;

      // Switches held high through reset: first clean update 13 cycles after release
      reset_n = 1'b1;
      k = 0; found = 1'b0;
      while (!found && k < 16) begin
         cyc(1);
         k++;
         if (sw_clean === 16'hFFFF) found = 1'b1;
      end
      chk("rst_release_done", {31'h0, found}, 32'h1);
      chk("rst_release_latency", k, 32'd13);
      cyc(1);
      bus_rd(2'd3, d);
      chk("rst_edgecap", d, IRQ_EN ? 32'h0000_FFFF : 32'h0);

      // Debounce: settle at 0, a 2-cycle glitch is rejected, a steady level passes
      sw_raw = 16'h0000;
      cyc(20);
      chk("settle_zero", {16'h0, sw_clean}, 32'h0);
      sw_raw = 16'h0008;
      cyc(2);
      sw_raw = 16'h0000;
      seen = '0;
      repeat (16) begin
         cyc(1);
         seen = seen | sw_clean;
      end
      chk("glitch_rejected", {16'h0, seen}, 32'h0);
      sw_raw = 16'h0008;
      cyc(20);
      chk("steady_bit3", {16'h0, sw_clean}, 32'h0000_0008);

      // Register readback; upper writedata bits and writes to 0/1 are ignored
      bus_wr(2'd2, 32'hFFFF_00F0);
      bus_rd(2'd2, d);
      chk("intmask_rb", d, IRQ_EN ? 32'h0000_00F0 : 32'h0);
      bus_wr(2'd0, 32'h0000_FFFF);
      bus_rd(2'd0, d);
      chk("rd_sw_clean", d, 32'h0000_0008);
      bus_wr(2'd1, 32'h0000_FFFF);
      bus_rd(2'd1, d);
      chk("rd_sw_sync", d, 32'h0000_0008);

      // IRQ on bit 4 with intmask = 0x0010
      bus_wr(2'd2, 32'h0000_0010);
      bus_wr(2'd3, 32'hFFFF_FFFF);
      chk("irq_idle", {31'h0, irq}, 32'h0);
      bus_rd(2'd3, d);
      chk("edgecap_cleared", d, 32'h0);
      sw_raw = 16'h0018;
      cyc(20);
      chk("irq_set", {31'h0, irq}, {31'h0, IRQ_EN});
      bus_rd(2'd3, d);
      chk("edgecap_bit4", d, IRQ_EN ? 32'h0000_0010 : 32'h0);
      bus_wr(2'd3, 32'h0000_0010);
      chk("irq_after_clear", {31'h0, irq}, 32'h0);
      bus_rd(2'd3, d);
      chk("edgecap_after_clear", d, 32'h0);

      // Masked bit: bit 3 edge is captured but raises no irq
      sw_raw = 16'h0010;
      cyc(20);
      chk("irq_masked", {31'h0, irq}, 32'h0);
      bus_rd(2'd3, d);
      chk("edgecap_bit3_fall", d, IRQ_EN ? 32'h0000_0008 : 32'h0);
      bus_wr(2'd3, 32'hFFFF_FFFF);

      // Read of edgecap in the same cycle as a new edge returns the old value
      sw_raw = 16'h0018;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cyc(1);
         if (sw_clean !== 16'h0010) found = 1'b1;
      end
      chk("wait_bit3_rise", {31'h0, found}, 32'h1);
      bus_rd(2'd3, d);
      chk("rd_vs_edge_old", d, 32'h0);
      bus_rd(2'd3, d);
      chk("rd_vs_edge_new", d, IRQ_EN ? 32'h0000_0008 : 32'h0);
      bus_wr(2'd3, 32'hFFFF_FFFF);

      // Collision: clear of bit 4 in the same cycle its edge is captured
      sw_raw = 16'h0008;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cyc(1);
         if (sw_clean[4] === 1'b0) found = 1'b1;
      end
      chk("wait_bit4_fall", {31'h0, found}, 32'h1);
      bus_wr(2'd3, 32'h0000_0010);
      chk("collision_irq", {31'h0, irq}, {31'h0, IRQ_EN});
      bus_rd(2'd3, d);
      chk("collision_edgecap", d, IRQ_EN ? 32'h0000_0010 : 32'h0);
      chk("final_sw_clean", {16'h0, sw_clean}, 32'h0000_0008);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
